// File: rtl/mmmul_sched_if.sv
// -----------------------------------------------------------------------------
// mmmul_sched_if
// Bundle of every signal between the round-robin scheduler, its requesters,
// its response consumer and the shared matrix-multiply engine.
//   req_valid/req_ready  per-requester job handshake (ready is one-hot)
//   req_m1/req_m2        per-requester operand matrices, requester i at slice i
//   rsp_*                tagged result returned to the consumer
//   busy                 scheduler not idle
//   eng_*                drive/observe the single engine
// Modports:
//   slave  - the scheduler itself
//   master - the surrounding environment (requesters, consumer, engine)
// -----------------------------------------------------------------------------
interface mmmul_sched_if #(
  parameter int N_REQ = 4,
  parameter int ROWS1 = 4,
  parameter int COLS1 = 4,
  parameter int COLS2 = 4,
  parameter int DW    = 32
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]                  req_valid;
  logic [N_REQ-1:0]                  req_ready;
  logic [N_REQ*ROWS1*COLS1*DW-1:0]   req_m1;
  logic [N_REQ*COLS1*COLS2*DW-1:0]   req_m2;
  logic                              rsp_valid;
  logic                              rsp_ready;
  logic [IDW-1:0]                    rsp_id;
  logic [ROWS1*COLS2*DW-1:0]         rsp_result;
  logic                              rsp_err;
  logic                              busy;
  logic                              eng_rst;
  logic [ROWS1*COLS1*DW-1:0]         eng_m1;
  logic [COLS1*COLS2*DW-1:0]         eng_m2;
  logic                              eng_done;
  logic [ROWS1*COLS2*DW-1:0]         eng_result;

  modport slave (
    input  req_valid, req_m1, req_m2, rsp_ready, eng_done, eng_result,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy,
           eng_rst, eng_m1, eng_m2
  );

  modport master (
    output req_valid, req_m1, req_m2, rsp_ready, eng_done, eng_result,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy,
           eng_rst, eng_m1, eng_m2
  );
endinterface

// File: rtl/mmmul_sched.sv
// -----------------------------------------------------------------------------
// mmmul_sched
// Round-robin scheduler sharing one matrix-multiply engine among N_REQ
// requesters. A granted job has its operands latched onto the engine, the
// engine is held in reset for RST_HOLD cycles, then the scheduler waits for a
// rising edge of eng_done and returns the engine result tagged with the
// requester id.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous, active-low reset
//   bus   mmmul_sched_if.slave - request, response and engine signals
// Configuration macro:
//   MMSCHED_TIMEOUT_EN - when defined, a RUN-cycle watchdog aborts a job after
//   TIMEOUT cycles without done and returns rsp_err=1 with a zero result.
//   When undefined, RUN waits indefinitely and rsp_err is constant 0.
// -----------------------------------------------------------------------------
module mmmul_sched #(
  parameter int N_REQ    = 4,
  parameter int ROWS1    = 4,
  parameter int COLS1    = 4,
  parameter int COLS2    = 4,
  parameter int DW       = 32,
  parameter int RST_HOLD = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic         clk,
  input  logic         rst,
  mmmul_sched_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int M1W = ROWS1*COLS1*DW;
  localparam int M2W = COLS1*COLS2*DW;
  localparam int RW  = ROWS1*COLS2*DW;
  localparam int HW  = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  if (N_REQ < 2 || RST_HOLD < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mmmul_sched: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_e;

  state_e         state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] id_q;
  logic [HW-1:0]  hold_q;
  logic           eng_done_q;
  logic           eng_rst_q;
  logic           rsp_valid_q;
  logic [M1W-1:0] eng_m1_q;
  logic [M2W-1:0] eng_m2_q;
  logic [RW-1:0]  rsp_result_q;

`ifdef MMSCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0]  run_cnt_q;
  logic           rsp_err_q;
`endif

  logic           found_d;
  logic [IDW-1:0] winner_d;
  logic [N_REQ-1:0] req_ready_d;
  logic           done_rise_d;

  // Winner is the first valid requester after the last one served, wrapping.
  always_comb begin : p_arb
    int idx;
    idx      = 0;
    found_d  = 1'b0;
    winner_d = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!found_d && bus.req_valid[idx[IDW-1:0]]) begin
        found_d  = 1'b1;
        winner_d = idx[IDW-1:0];
      end
    end
  end

  // Grant only while idle and out of reset so req_ready reads 0 during reset.
  always_comb begin
    req_ready_d = '0;
    if (rst && state_q == S_IDLE && found_d)
      req_ready_d[winner_d] = 1'b1;
  end

  // A done level left over from a previous job must not complete this one.
  assign done_rise_d = bus.eng_done & ~eng_done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= IDW'(N_REQ-1);
      id_q         <= '0;
      hold_q       <= '0;
      eng_done_q   <= 1'b0;
      eng_rst_q    <= 1'b1;
      rsp_valid_q  <= 1'b0;
      eng_m1_q     <= '0;
      eng_m2_q     <= '0;
      rsp_result_q <= '0;
`ifdef MMSCHED_TIMEOUT_EN
      run_cnt_q    <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      eng_done_q <= bus.eng_done;
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            eng_m1_q <= bus.req_m1[winner_d*M1W +: M1W];
            eng_m2_q <= bus.req_m2[winner_d*M2W +: M2W];
            id_q     <= winner_d;
            rr_ptr_q <= winner_d;
            hold_q   <= '0;
            state_q  <= S_LOAD;
          end
        end
        // eng_rst is already high here; it drops on the way into RUN.
        S_LOAD: begin
          if (hold_q == HW'(RST_HOLD-1)) begin
            eng_rst_q <= 1'b0;
            state_q   <= S_RUN;
`ifdef MMSCHED_TIMEOUT_EN
            run_cnt_q <= '0;
`endif
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        S_RUN: begin
          if (done_rise_d) begin
            rsp_result_q <= bus.eng_result;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
`ifdef MMSCHED_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
          end else if (run_cnt_q == CW'(TIMEOUT)) begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
`endif
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            eng_rst_q   <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_d;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.eng_rst    = eng_rst_q;
  assign bus.eng_m1     = eng_m1_q;
  assign bus.eng_m2     = eng_m2_q;
`ifdef MMSCHED_TIMEOUT_EN
  assign bus.rsp_err    = rsp_err_q;
`else
  assign bus.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mmmul_sched.sv
// -----------------------------------------------------------------------------
// tb_mmmul_sched
// Directed bench for mmmul_sched with a behavioural engine (integer-valued
// float matrices), a transaction-level reference model and a per-cycle
// compare process, plus literal expectations for each scenario.
// Honours MMSCHED_TIMEOUT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mmmul_sched;
  localparam int N_REQ = 4, ROWS1 = 4, COLS1 = 4, COLS2 = 4, DW = 32;
  localparam int RST_HOLD = 2, TIMEOUT = 16, ENG_LAT = 5;
  localparam int EW = ROWS1*COLS1*DW;
  typedef logic [EW-1:0] mat_t;

  localparam logic [31:0] ONE = 32'h3F800000, TWO = 32'h40000000;
  localparam logic [31:0] THREE = 32'h40400000, FOUR = 32'h40800000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mmmul_sched_if #(.N_REQ(N_REQ), .ROWS1(ROWS1), .COLS1(COLS1), .COLS2(COLS2), .DW(DW)) bus ();

  mmmul_sched #(.N_REQ(N_REQ), .ROWS1(ROWS1), .COLS1(COLS1), .COLS2(COLS2), .DW(DW),
                .RST_HOLD(RST_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input mat_t act, input mat_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- float helpers (exact for small non-negative integers)
  function automatic int f2i(input logic [31:0] b);
    int e;
    logic [23:0] m;
    if (b[30:0] == 31'd0) return 0;
    e = int'(b[30:23]) - 127;
    m = {1'b1, b[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] i2f(input int v);
    int e;
    logic [31:0] sh;
    if (v == 0) return 32'd0;
    e = 0;
    for (int i = 0; i < 31; i++) if (v[i]) e = i;
    sh = 32'(v) << (23 - e);
    return {1'b0, 8'(e + 127), sh[22:0]};
  endfunction

  function automatic mat_t matmul(input mat_t a, input mat_t b);
    mat_t res;
    int acc;
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        acc = 0;
        for (int k = 0; k < 4; k++)
          acc += f2i(a[(r*4+k)*32 +: 32]) * f2i(b[(k*4+c)*32 +: 32]);
        res[(r*4+c)*32 +: 32] = i2f(acc);
      end
    return res;
  endfunction

  function automatic mat_t diag(input logic [31:0] f);
    mat_t res;
    res = '0;
    for (int i = 0; i < 4; i++) res[(i*4+i)*32 +: 32] = f;
    return res;
  endfunction

  // Round-robin rule: first valid requester after the last one served.
  function automatic int pick(input logic [N_REQ-1:0] v, input int last);
    for (int k = 1; k <= N_REQ; k++)
      if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
    return -1;
  endfunction

  // ---------------- requesters: want[i] = jobs still to be issued by i
  int want[N_REQ];
  int grant_cnt = 0;

  always @(negedge clk)
    for (int i = 0; i < N_REQ; i++) bus.req_valid[i] = (want[i] > 0);

  always @(posedge clk)
    if (rst)
      for (int i = 0; i < N_REQ; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          want[i]--;
          grant_cnt++;
        end

  // ---------------- behavioural engine: done rises ENG_LAT cycles after release
  int   eng_cnt = 0;
  logic eng_mute = 1'b0;

  always @(negedge clk) begin
    if (!rst || bus.eng_rst) begin
      eng_cnt      = 0;
      bus.eng_done = 1'b0;
    end else if (!eng_mute) begin
      eng_cnt++;
      if (eng_cnt == ENG_LAT) begin
        bus.eng_result = matmul(bus.eng_m1, bus.eng_m2);
        bus.eng_done   = 1'b1;
      end
    end
  end

  // ---------------- response log
  int   act_id[$];
  mat_t act_res[$];

  always @(posedge clk)
    if (rst && bus.rsp_valid && bus.rsp_ready) begin
      act_id.push_back(int'(bus.rsp_id));
      act_res.push_back(bus.rsp_result);
    end

  // ---------------- reference model: 0 idle, 1 job in flight, 2 response pending
  int   m_phase = 0, m_last = N_REQ-1, m_since = 0, m_id = 0;
  logic m_prev = 1'b0, m_err = 1'b0;
  mat_t m_m1 = '0, m_m2 = '0, m_res = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_last = N_REQ-1; m_since = 0; m_prev = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          int w;
          w = pick(bus.req_valid, m_last);
          if (w >= 0) begin
            m_last = w; m_id = w;
            m_m1 = bus.req_m1[w*EW +: EW];
            m_m2 = bus.req_m2[w*EW +: EW];
            m_res = matmul(m_m1, m_m2);
            m_err = 1'b0;
            m_since = 1; m_phase = 1;
          end
        end
        1: begin
          if (m_since > RST_HOLD && bus.eng_done && !m_prev) m_phase = 2;
`ifdef MMSCHED_TIMEOUT_EN
          else if (m_since - RST_HOLD - 1 == TIMEOUT) begin
            m_phase = 2; m_err = 1'b1; m_res = '0;
          end
`endif
          else m_since++;
        end
        default: if (bus.rsp_ready) m_phase = 0;
      endcase
      m_prev = bus.eng_done;
    end
  end

  // ---------------- per-cycle compare
  always @(posedge clk or negedge rst) begin
    logic [N_REQ-1:0] er;
    int w;
    #1;
    er = '0;
    if (rst && m_phase == 0) begin
      w = pick(bus.req_valid, m_last);
      if (w >= 0) er[w] = 1'b1;
    end
    chk("req_ready", bus.req_ready, er);
    chk("busy", bus.busy, (m_phase != 0));
    chk("eng_rst", bus.eng_rst, (m_phase == 0) || (m_phase == 1 && m_since <= RST_HOLD));
    chk("rsp_valid", bus.rsp_valid, (m_phase == 2));
    if (!rst) begin
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_result", bus.rsp_result, '0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_eng_m1", bus.eng_m1, '0);
      chk("rst_eng_m2", bus.eng_m2, '0);
    end else begin
      if (m_phase != 0) begin
        chk("eng_m1", bus.eng_m1, m_m1);
        chk("eng_m2", bus.eng_m2, m_m2);
      end
      if (m_phase == 2) begin
        chk("rsp_id", bus.rsp_id, m_id);
        chk("rsp_result", bus.rsp_result, m_res);
        chk("rsp_err", bus.rsp_err, m_err);
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic set_ops(input int i, input mat_t a, input mat_t b);
    bus.req_m1[i*EW +: EW] = a;
    bus.req_m2[i*EW +: EW] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) want[i] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_acts(input int n);
    for (int c = 0; c < 400 && act_id.size() < n; c++) @(negedge clk);
    chk("rsp_count", act_id.size(), n);
  endtask

  task automatic wait_run(input string nm);
    int c;
    c = 0;
    while (!(bus.busy && !bus.eng_rst) && c < 60) begin
      @(posedge clk); #1; c++;
    end
    if (c >= 60) chk(nm, 0, 1);
  endtask

  // ---------------- directed scenarios
  initial begin
    int g0, cnt;
    mat_t r0, a3;
    logic [31:0] kf[4];
    logic seen;
    kf[0] = ONE; kf[1] = TWO; kf[2] = THREE; kf[3] = FOUR;
    bus.req_valid = '0; bus.req_m1 = '0; bus.req_m2 = '0; bus.rsp_ready = 1'b1;
    bus.eng_done = 1'b0; bus.eng_result = '0;
    for (int i = 0; i < N_REQ; i++) want[i] = 0;
    repeat (3) @(negedge clk);
    chk("reset_eng_rst", bus.eng_rst, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    rst = 1'b1;

    // 1: single request, identity operands
    set_ops(0, diag(ONE), diag(ONE));
    g0 = grant_cnt;
    want[0] = 1;
    for (int c = 0; c < 50 && grant_cnt == g0; c++) begin @(posedge clk); #1; end
    chk("t1_eng_rst_T1", bus.eng_rst, 1);
    @(posedge clk); #1;
    chk("t1_eng_rst_T2", bus.eng_rst, 1);
    @(posedge clk); #1;
    chk("t1_eng_rst_T3", bus.eng_rst, 0);
    wait_acts(1);
    if (act_id.size() >= 1) begin
      chk("t1_id", act_id[0], 0);
      chk("t1_result", act_res[0], diag(ONE));
    end

    // 2: all requesters valid, A=k*I, B=I
    do_reset();
    act_id.delete(); act_res.delete();
    for (int i = 0; i < N_REQ; i++) set_ops(i, diag(kf[i]), diag(ONE));
    want[0] = 2; want[1] = 1; want[2] = 1; want[3] = 1;
    wait_acts(5);
    if (act_id.size() >= 5)
      for (int j = 0; j < 5; j++) begin
        chk($sformatf("t2_id%0d", j), act_id[j], j % 4);
        chk($sformatf("t2_result%0d", j), act_res[j], diag(kf[j % 4]));
      end

    // 3: rotation after serving req1
    act_id.delete(); act_res.delete();
    want[1] = 1;
    wait_acts(1);
    a3 = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) a3[(r*4+c)*32 +: 32] = i2f(r + c + 1);
    set_ops(3, a3, diag(TWO));
    want[1] = 1; want[3] = 1;
    wait_acts(3);
    if (act_id.size() >= 3) begin
      chk("t3_first", act_id[1], 3);
      chk("t3_second", act_id[2], 1);
      chk("t3_elem00", act_res[1][31:0], TWO);
      chk("t3_elem01", act_res[1][63:32], FOUR);
    end

    // 4: consumer stalls for 10 cycles
    act_id.delete(); act_res.delete();
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    want[2] = 1;
    for (int c = 0; c < 60 && !bus.rsp_valid; c++) begin @(posedge clk); #1; end
    r0 = bus.rsp_result;
    chk("t4_result", r0, diag(THREE));
    want[0] = 1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", bus.rsp_valid, 1);
      chk("t4_hold_id", bus.rsp_id, 2);
      chk("t4_hold_result", bus.rsp_result, r0);
      chk("t4_hold_ready", bus.req_ready, 0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    wait_acts(2);
    if (act_id.size() >= 2) chk("t4_next", act_id[1], 0);

    // 5: reset during RUN
    act_id.delete(); act_res.delete();
    want[1] = 1;
    wait_run("t5_reach_run");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_busy", bus.busy, 0);
    chk("t5_eng_rst", bus.eng_rst, 1);
    chk("t5_rsp_valid", bus.rsp_valid, 0);
    chk("t5_eng_m1", bus.eng_m1, '0);
    want[0] = 1; want[2] = 1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_acts(2);
    if (act_id.size() >= 2) begin
      chk("t5_first", act_id[0], 0);
      chk("t5_second", act_id[1], 2);
    end

    // 6: engine never finishes
    act_id.delete(); act_res.delete();
    eng_mute = 1'b1;
    want[3] = 1;
`ifdef MMSCHED_TIMEOUT_EN
    wait_run("t6_reach_run");
    cnt = 0;
    while (!bus.rsp_valid && cnt < 100) begin @(posedge clk); #1; cnt++; end
    chk("t6_latency", cnt, 17);
    chk("t6_err", bus.rsp_err, 1);
    chk("t6_result", bus.rsp_result, '0);
    @(negedge clk);
    eng_mute = 1'b0;
    wait_acts(1);
`else
    seen = 1'b0;
    cnt = 0;
    repeat (2000) begin @(posedge clk); #1; if (bus.rsp_valid) seen = 1'b1; cnt++; end
    chk("t6_no_rsp", seen, 0);
    do_reset();
    eng_mute = 1'b0;
`endif
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
